serial_subtractor: RTL

//  Parametrised bit-serial subtractor: computes diff = a - b - bin over WIDTH bits, LSB first,
//  one bit per clock through a single registered-borrow full-subtractor cell.

---
 rtl/sub_pkg.sv | 22 ++
 rtl/full_subtractor_cell.sv | 23 ++
 rtl/serial_subtractor.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Purpose: shared definitions for the bit-serial subtractor family.
//   - state_e : FSM state encodings of the serial datapath controller
//   - fs_bit  : one-bit full-subtractor equation, returns {borrow_out, diff}
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // d = a ^ b ^ bin; a borrow leaves the cell when b (or a propagated
  // borrow on equal bits) exceeds a.
  function automatic logic [1:0] fs_bit(input logic a, input logic b, input logic bin);
    logic d;
    logic bo;
    d  = a ^ b ^ bin;
    bo = (~a & b) | (~(a ^ b) & bin);
    return {bo, d};
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Purpose: combinational one-bit full subtractor (a - b - bin).
// Ports:
//   a, b  : operand bits
//   bin   : borrow in
//   diff  : difference bit
//   bout  : borrow out
module full_subtractor_cell
  import sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic [1:0] w_res;

  assign w_res = fs_bit(a, b, bin);
  assign diff  = w_res[0];
  assign bout  = w_res[1];

endmodule

// File: rtl/serial_subtractor.sv
// Purpose: bit-serial subtractor, diff = a - b - bin over WIDTH bits, LSB
//   first, one bit per clock through a single full-subtractor cell whose
//   borrow is registered between bits. Result, borrow-out and signed
//   overflow are held until the next operation completes.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, accepted only when idle or on the done cycle
//   a, b   : minuend / subtrahend, captured on an accepted start
//   bin    : borrow-in, captured on an accepted start
//   busy   : high while bits are being processed
//   done   : one-cycle pulse when diff/bout/ovf have just been updated
//   diff   : a - b - bin modulo 2^WIDTH
//   bout   : final borrow-out (unsigned a < b + bin)
//   ovf    : two's complement overflow of the subtraction
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_r_sh;
  logic               r_br;
  logic               r_a_msb;
  logic               r_b_msb;

  logic               w_d;
  logic               w_bout;
  logic               w_last;
  logic [WIDTH-1:0]   w_r_next;

  full_subtractor_cell u_cell (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .bin  (r_br),
    .diff (w_d),
    .bout (w_bout)
  );

  // New difference bit enters at the MSB end, so after WIDTH shifts the
  // first (LSB) bit has reached position 0. Written as a shift so that
  // WIDTH=1 needs no special case.
  assign w_r_next = (r_r_sh >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_r_sh  <= '0;
      r_br    <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        // Accept: operands are only sampled here, so a start during SHIFT
        // can never disturb the operation in flight.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_br    <= bin;
            r_r_sh  <= '0;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            busy    <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        // One bit per clock through the cell; the last bit updates the
        // held outputs directly from the combinational next values.
        ST_SHIFT: begin
          r_br   <= w_bout;
          r_r_sh <= w_r_next;
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            diff    <= w_r_next;
            bout    <= w_bout;
            // Signed overflow: operands of different sign and the result
            // sign differs from the minuend. The final bit is the MSB.
            ovf     <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
